// File: rtl/lb_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : lb_rr_arbiter
//  Purpose  : Round-robin arbiter that shares one LBL local bus master port
//             between NREQ requesters. Each requester gets one request slot.
//             Slots are served one at a time. Reads are tracked until
//             lb_rvalid arrives or a timeout expires, and the read data is
//             then routed back to the owning requester.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk         system clock, rising edge
//    rst         synchronous active-high reset
//    req_write   per-requester single-cycle write strobe        [NREQ]
//    req_read    per-requester single-cycle read strobe         [NREQ]
//    req_addr    packed addresses, requester i at [i*ADW +: ADW]
//    req_wdata   packed write data, requester i at [i*32 +: 32]
//    req_busy    requester i has a request pending or in flight [NREQ]
//    req_rdata   shared read data, qualified by req_rvalid      [32]
//    req_rvalid  one-hot, one-cycle read completion pulse       [NREQ]
//    req_rerr    one-cycle pulse with req_rvalid on read timeout[NREQ]
//    lb_write    downstream write strobe
//    lb_read     downstream read strobe
//    lb_addr     downstream address                             [ADW]
//    lb_wdata    downstream write data                          [32]
//    lb_rdata    downstream read data                           [32]
//    lb_rvalid   downstream read data valid
//    drop_err    sticky: a strobe arrived while its requester was busy
// ============================================================================
module lb_rr_arbiter #(
    parameter int          NREQ     = 4,
    parameter int          ADW      = 20,
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hdeadbeef
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_write,
    input  logic [NREQ-1:0]     req_read,
    input  logic [NREQ*ADW-1:0] req_addr,
    input  logic [NREQ*32-1:0]  req_wdata,
    output logic [NREQ-1:0]     req_busy,
    output logic [31:0]         req_rdata,
    output logic [NREQ-1:0]     req_rvalid,
    output logic [NREQ-1:0]     req_rerr,
    output logic                lb_write,
    output logic                lb_read,
    output logic [ADW-1:0]      lb_addr,
    output logic [31:0]         lb_wdata,
    input  logic [31:0]         lb_rdata,
    input  logic                lb_rvalid,
    output logic                drop_err
);

    localparam int          PTRW    = (NREQ > 1) ? $clog2(NREQ) : 1;
    // Last WAIT_RD count value before a read is abandoned.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Request slots
    // ------------------------------------------------------------------
    logic [NREQ-1:0] pending;
    logic [NREQ-1:0] slot_wr;
    logic [ADW-1:0]  slot_addr  [NREQ];
    logic [31:0]     slot_wdata [NREQ];

    // ------------------------------------------------------------------
    // Arbitration / transaction state
    // ------------------------------------------------------------------
    state_t          state;
    logic [PTRW-1:0] ptr;
    logic [PTRW-1:0] gnt;
    logic [15:0]     cnt;

    logic            any_pend;
    logic [PTRW-1:0] pick;
    logic [PTRW:0]   scan_sum;
    logic [PTRW-1:0] scan_idx;
    logic            slot_done;
    logic [PTRW-1:0] next_ptr;
    logic [NREQ-1:0] gnt_oh;

    // busy is exactly the registered pending flag of each slot
    assign req_busy = pending;

    // ------------------------------------------------------------------
    // Round-robin pick: first pending slot at or above ptr, wrapping.
    // Scanning from the far end downward lets the nearest hit win.
    // ------------------------------------------------------------------
    always_comb begin
        any_pend = 1'b0;
        pick     = '0;
        scan_sum = '0;
        scan_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            scan_sum = {1'b0, ptr} + (PTRW + 1)'(k);
            if (scan_sum >= (PTRW + 1)'(NREQ)) begin
                scan_sum = scan_sum - (PTRW + 1)'(NREQ);
            end
            scan_idx = scan_sum[PTRW-1:0];
            if (pending[scan_idx]) begin
                any_pend = 1'b1;
                pick     = scan_idx;
            end
        end
    end

    // ------------------------------------------------------------------
    // Transaction end detection. A read answered in the strobe cycle
    // completes straight from ISSUE. In WAIT_RD, lb_rvalid has priority
    // over the timeout so a response in the final cycle is not an error.
    // ------------------------------------------------------------------
    always_comb begin
        slot_done = 1'b0;
        case (state)
            ISSUE:   slot_done = slot_wr[gnt] | lb_rvalid;
            WAIT_RD: slot_done = lb_rvalid | (cnt == TO_LAST);
            default: slot_done = 1'b0;
        endcase
    end

    assign next_ptr = (gnt == PTRW'(NREQ - 1)) ? '0 : gnt + 1'b1;
    assign gnt_oh   = NREQ'(1) << gnt;

    // ------------------------------------------------------------------
    // Slot capture and release
    // ------------------------------------------------------------------
    // A slot can never be captured and released at the same edge, because
    // release requires the slot to be pending and capture requires it not
    // to be.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= '0;
            slot_wr  <= '0;
            drop_err <= 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                slot_addr[i]  <= '0;
                slot_wdata[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (slot_done && (gnt == PTRW'(i))) begin
                    pending[i] <= 1'b0;
                end
                if (req_write[i] || req_read[i]) begin
                    if (pending[i]) begin
                        drop_err <= 1'b1;
                    end else begin
                        pending[i]    <= 1'b1;
                        // write wins when both strobes arrive together
                        slot_wr[i]    <= req_write[i];
                        slot_addr[i]  <= req_addr[i*ADW +: ADW];
                        slot_wdata[i] <= req_wdata[i*32 +: 32];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Downstream sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            gnt        <= '0;
            cnt        <= '0;
            lb_write   <= 1'b0;
            lb_read    <= 1'b0;
            lb_addr    <= '0;
            lb_wdata   <= '0;
            req_rdata  <= '0;
            req_rvalid <= '0;
            req_rerr   <= '0;
        end else begin
            // strobes and completion pulses last a single cycle
            lb_write   <= 1'b0;
            lb_read    <= 1'b0;
            req_rvalid <= '0;
            req_rerr   <= '0;

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (any_pend) begin
                        gnt      <= pick;
                        lb_addr  <= slot_addr[pick];
                        lb_wdata <= slot_wdata[pick];
                        lb_write <= slot_wr[pick];
                        lb_read  <= ~slot_wr[pick];
                        state    <= ISSUE;
                    end
                end

                ISSUE: begin
                    if (slot_wr[gnt]) begin
                        ptr   <= next_ptr;
                        state <= IDLE;
                    end else if (lb_rvalid) begin
                        req_rdata  <= lb_rdata;
                        req_rvalid <= gnt_oh;
                        ptr        <= next_ptr;
                        state      <= IDLE;
                    end else begin
                        state <= WAIT_RD;
                    end
                end

                WAIT_RD: begin
                    if (lb_rvalid) begin
                        req_rdata  <= lb_rdata;
                        req_rvalid <= gnt_oh;
                        ptr        <= next_ptr;
                        cnt        <= '0;
                        state      <= IDLE;
                    end else if (cnt == TO_LAST) begin
                        req_rdata  <= ERR_DATA;
                        req_rvalid <= gnt_oh;
                        req_rerr   <= gnt_oh;
                        ptr        <= next_ptr;
                        cnt        <= '0;
                        state      <= IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lb_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lb_rr_arbiter
//  Purpose  : Directed bench for lb_rr_arbiter. The stimulus queues the
//             expected downstream strobes, read completions and per-cycle
//             probes. A separate negedge monitor pops and compares them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lb_rr_arbiter;

    localparam int          NREQ     = 4;
    localparam int          ADW      = 20;
    localparam int          TIMEOUT  = 8;
    localparam logic [31:0] ERR_DATA = 32'hdeadbeef;

    localparam int SEL_BUSY = 0, SEL_DROP = 1, SEL_ADDR = 2, SEL_LBW = 3,
                   SEL_LBR = 4, SEL_RDATA = 5, SEL_RVALID = 6, SEL_WDATA = 7,
                   SEL_RERR = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_write, req_read;
    logic [NREQ*ADW-1:0] req_addr;
    logic [NREQ*32-1:0]  req_wdata;
    logic [NREQ-1:0]     req_busy, req_rvalid, req_rerr;
    logic [31:0]         req_rdata;
    logic                lb_write, lb_read;
    logic [ADW-1:0]      lb_addr;
    logic [31:0]         lb_wdata, lb_rdata;
    logic                lb_rvalid;
    logic                drop_err;

    lb_rr_arbiter #(
        .NREQ(NREQ), .ADW(ADW), .TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)
    ) dut (
        .clk(clk), .rst(rst),
        .req_write(req_write), .req_read(req_read),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_busy(req_busy), .req_rdata(req_rdata),
        .req_rvalid(req_rvalid), .req_rerr(req_rerr),
        .lb_write(lb_write), .lb_read(lb_read),
        .lb_addr(lb_addr), .lb_wdata(lb_wdata),
        .lb_rdata(lb_rdata), .lb_rvalid(lb_rvalid),
        .drop_err(drop_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; bit wr; logic [ADW-1:0] addr; logic [31:0] data; } lb_exp_t;
    typedef struct { int cyc; logic [NREQ-1:0] rv; logic [NREQ-1:0] re; logic [31:0] data; } rd_exp_t;
    typedef struct { int cyc; string name; int sel; logic [31:0] want; } probe_t;

    lb_exp_t lbq[$];
    rd_exp_t rdq[$];
    probe_t  pq[$];

    int          checks = 0;
    int          errors = 0;
    bit          fin = 1'b0;
    bit          stim_timeout = 1'b0;
    bit          resp_en;
    int          resp_d;
    logic [31:0] resp_data;
    int          t, t2;

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input bit wr, input bit rd,
                           input logic [ADW-1:0] a, input logic [31:0] d);
        req_write[i] = wr;
        req_read[i]  = rd;
        req_addr[i*ADW +: ADW] = a;
        req_wdata[i*32 +: 32]  = d;
    endtask

    task automatic clear_reqs();
        req_write = '0;
        req_read  = '0;
    endtask

    task automatic exp_lb(input int c, input bit wr, input logic [ADW-1:0] a,
                          input logic [31:0] d);
        lbq.push_back('{cyc: c, wr: wr, addr: a, data: d});
    endtask

    task automatic exp_rd(input int c, input logic [NREQ-1:0] rv,
                          input logic [NREQ-1:0] re, input logic [31:0] d);
        rdq.push_back('{cyc: c, rv: rv, re: re, data: d});
    endtask

    task automatic probe(input int c, input string n, input int s, input logic [31:0] w);
        pq.push_back('{cyc: c, name: n, sel: s, want: w});
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (req_busy !== '0 && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) stim_timeout = 1'b1;
        repeat (3) tick();
    endtask

    // ---------------- downstream read responder ----------------
    initial begin
        lb_rvalid = 1'b0;
        lb_rdata  = '0;
        forever begin
            @(negedge clk);
            if (lb_read && resp_en) begin
                repeat (resp_d) @(negedge clk);
                lb_rvalid = 1'b1;
                lb_rdata  = resp_data;
                @(negedge clk);
                lb_rvalid = 1'b0;
                lb_rdata  = '0;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        lb_exp_t     le;
        rd_exp_t     re;
        probe_t      p;
        logic [31:0] act;

        if (lb_write || lb_read) begin
            checks++;
            if (lbq.size() == 0) begin
                errors++;
                $display("FAIL lb_unexpected: cycle %0d got wr=%0b rd=%0b addr=%h, required no strobe",
                         cyc, lb_write, lb_read, lb_addr);
            end else begin
                le = lbq.pop_front();
                if (lb_write !== le.wr || lb_read !== !le.wr || lb_addr !== le.addr ||
                    (le.wr && lb_wdata !== le.data) || cyc != le.cyc) begin
                    errors++;
                    $display("FAIL lb_txn: got cyc=%0d wr=%0b rd=%0b addr=%h wdata=%h, required cyc=%0d wr=%0b addr=%h wdata=%h",
                             cyc, lb_write, lb_read, lb_addr, lb_wdata, le.cyc, le.wr, le.addr, le.data);
                end
            end
        end

        if ((|req_rvalid) || (|req_rerr)) begin
            checks++;
            if (rdq.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: cycle %0d got rvalid=%b rerr=%b, required none",
                         cyc, req_rvalid, req_rerr);
            end else begin
                re = rdq.pop_front();
                if (req_rvalid !== re.rv || req_rerr !== re.re || req_rdata !== re.data ||
                    cyc != re.cyc) begin
                    errors++;
                    $display("FAIL rd_cpl: got cyc=%0d rvalid=%b rerr=%b rdata=%h, required cyc=%0d rvalid=%b rerr=%b rdata=%h",
                             cyc, req_rvalid, req_rerr, req_rdata, re.cyc, re.rv, re.re, re.data);
                end
            end
        end

        while (pq.size() > 0 && pq[0].cyc <= cyc) begin
            p = pq.pop_front();
            case (p.sel)
                SEL_BUSY:   act = 32'(req_busy);
                SEL_DROP:   act = 32'(drop_err);
                SEL_ADDR:   act = 32'(lb_addr);
                SEL_LBW:    act = 32'(lb_write);
                SEL_LBR:    act = 32'(lb_read);
                SEL_RDATA:  act = req_rdata;
                SEL_RVALID: act = 32'(req_rvalid);
                SEL_WDATA:  act = lb_wdata;
                SEL_RERR:   act = 32'(req_rerr);
                default:    act = 'x;
            endcase
            checks++;
            if (p.cyc != cyc || act !== p.want) begin
                errors++;
                $display("FAIL %s: cycle %0d got %h, required %h at cycle %0d",
                         p.name, cyc, act, p.want, p.cyc);
            end
        end

        if (fin) begin
            checks++;
            if (lbq.size() != 0 || rdq.size() != 0 || pq.size() != 0) begin
                errors++;
                $display("FAIL drain: got %0d lb, %0d rd, %0d probe entries left, required 0",
                         lbq.size(), rdq.size(), pq.size());
            end
            checks++;
            if (stim_timeout) begin
                errors++;
                $display("FAIL busy_wait: got busy stuck high, required release within 100 cycles");
            end
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required finish before 200000 time units");
        $fatal(1);
    end

    // ---------------- directed stimulus ----------------
    initial begin
        rst = 1'b1;
        req_write = '0; req_read = '0; req_addr = '0; req_wdata = '0;
        resp_en = 1'b0; resp_d = 0; resp_data = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        t = cyc;
        probe(t, "rst_busy",   SEL_BUSY,   0);
        probe(t, "rst_lbw",    SEL_LBW,    0);
        probe(t, "rst_lbr",    SEL_LBR,    0);
        probe(t, "rst_addr",   SEL_ADDR,   0);
        probe(t, "rst_wdata",  SEL_WDATA,  0);
        probe(t, "rst_rvalid", SEL_RVALID, 0);
        probe(t, "rst_rerr",   SEL_RERR,   0);
        probe(t, "rst_rdata",  SEL_RDATA,  0);
        probe(t, "rst_drop",   SEL_DROP,   0);
        tick();
        rst = 1'b0;

        // Round robin: all four at once, ptr=0 -> order 0,1,2,3
        tick();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, ADW'(i), 32'h100 + 32'(i));
        t = cyc;
        for (int i = 0; i < NREQ; i++) exp_lb(t + 2 + 2*i, 1'b1, ADW'(i), 32'h100 + 32'(i));
        tick(); clear_reqs(); wait_idle();

        // ptr back at 0: req0 and req3 together -> req0 first
        tick();
        set_req(0, 1'b1, 1'b0, 20'h00010, 32'h200);
        set_req(3, 1'b1, 1'b0, 20'h00013, 32'h203);
        t = cyc;
        exp_lb(t + 2, 1'b1, 20'h00010, 32'h200);
        exp_lb(t + 4, 1'b1, 20'h00013, 32'h203);
        tick(); clear_reqs(); wait_idle();

        // Single write on req0 with busy timing and address hold
        tick();
        set_req(0, 1'b1, 1'b0, 20'h00123, 32'h5a5a0001);
        t = cyc;
        exp_lb(t + 2, 1'b1, 20'h00123, 32'h5a5a0001);
        probe(t + 1, "wr_busy_t1", SEL_BUSY, 4'b0001);
        probe(t + 2, "wr_busy_t2", SEL_BUSY, 4'b0001);
        probe(t + 3, "wr_busy_t3", SEL_BUSY, 4'b0000);
        probe(t + 4, "addr_hold",  SEL_ADDR, 32'h00123);
        probe(t + 4, "wdata_hold", SEL_WDATA, 32'h5a5a0001);
        tick(); clear_reqs(); wait_idle();

        // ptr=1: req0 and req2 together -> req2 first
        tick();
        set_req(0, 1'b1, 1'b0, 20'h00020, 32'h300);
        set_req(2, 1'b1, 1'b0, 20'h00022, 32'h302);
        t = cyc;
        exp_lb(t + 2, 1'b1, 20'h00022, 32'h302);
        exp_lb(t + 4, 1'b1, 20'h00020, 32'h300);
        tick(); clear_reqs(); wait_idle();

        // Read on req2, D=3
        resp_en = 1'b1; resp_d = 3; resp_data = 32'hcafef00d;
        tick();
        set_req(2, 1'b0, 1'b1, 20'h00040, 32'h0);
        t = cyc;
        exp_lb(t + 2, 1'b0, 20'h00040, 32'h0);
        exp_rd(t + 6, 4'b0100, 4'b0000, 32'hcafef00d);
        probe(t + 5, "rd3_busy_hi", SEL_BUSY, 4'b0100);
        probe(t + 6, "rd3_busy_lo", SEL_BUSY, 4'b0000);
        tick(); clear_reqs(); wait_idle();

        // Read on req1, D=0 (answered in the strobe cycle)
        resp_d = 0; resp_data = 32'h01234567;
        tick();
        set_req(1, 1'b0, 1'b1, 20'h00041, 32'h0);
        t = cyc;
        exp_lb(t + 2, 1'b0, 20'h00041, 32'h0);
        exp_rd(t + 3, 4'b0010, 4'b0000, 32'h01234567);
        tick(); clear_reqs(); wait_idle();

        // Timeout on req3; the late response is ignored
        resp_d = 10; resp_data = 32'h0badf00d;
        tick();
        set_req(3, 1'b0, 1'b1, 20'h0007f, 32'h0);
        t = cyc;
        exp_lb(t + 2, 1'b0, 20'h0007f, 32'h0);
        exp_rd(t + 11, 4'b1000, 4'b1000, ERR_DATA);
        tick(); clear_reqs(); wait_idle();
        repeat (6) tick();

        // Response in the final WAIT_RD cycle wins over the timeout
        resp_d = 8; resp_data = 32'h600d600d;
        tick();
        set_req(0, 1'b0, 1'b1, 20'h00080, 32'h0);
        t = cyc;
        exp_lb(t + 2, 1'b0, 20'h00080, 32'h0);
        exp_rd(t + 11, 4'b0001, 4'b0000, 32'h600d600d);
        tick(); clear_reqs(); wait_idle();

        // Strobe on req1 while busy: dropped, drop_err set
        tick();
        set_req(1, 1'b1, 1'b0, 20'h00222, 32'h22220000);
        t = cyc;
        exp_lb(t + 2, 1'b1, 20'h00222, 32'h22220000);
        probe(t + 1, "drop_before", SEL_DROP, 0);
        probe(t + 2, "drop_set",    SEL_DROP, 1);
        tick();
        set_req(1, 1'b1, 1'b0, 20'h00333, 32'h33330000);
        tick(); clear_reqs(); wait_idle();

        // Write and read together on req2: treated as a write
        tick();
        set_req(2, 1'b1, 1'b1, 20'h00777, 32'h11112222);
        t = cyc;
        exp_lb(t + 2, 1'b1, 20'h00777, 32'h11112222);
        tick(); clear_reqs(); wait_idle();

        // Re-strobe in the same cycle busy drops
        tick();
        set_req(0, 1'b1, 1'b0, 20'h00050, 32'ha0);
        t = cyc;
        exp_lb(t + 2, 1'b1, 20'h00050, 32'ha0);
        probe(t + 3, "b2b_busy_lo", SEL_BUSY, 4'b0000);
        tick(); clear_reqs();
        tick(); tick();
        set_req(0, 1'b1, 1'b0, 20'h00051, 32'ha1);
        t2 = cyc;
        exp_lb(t2 + 2, 1'b1, 20'h00051, 32'ha1);
        tick(); clear_reqs(); wait_idle();

        // Reset during WAIT_RD: no completion, everything cleared
        resp_en = 1'b0;
        tick();
        set_req(1, 1'b0, 1'b1, 20'h00099, 32'h0);
        t = cyc;
        exp_lb(t + 2, 1'b0, 20'h00099, 32'h0);
        tick(); clear_reqs();
        tick(); tick(); tick();
        rst = 1'b1;
        probe(t + 5, "mrst_busy",   SEL_BUSY,   0);
        probe(t + 5, "mrst_lbr",    SEL_LBR,    0);
        probe(t + 5, "mrst_addr",   SEL_ADDR,   0);
        probe(t + 5, "mrst_rvalid", SEL_RVALID, 0);
        probe(t + 5, "mrst_drop",   SEL_DROP,   0);
        tick();
        rst = 1'b0;
        repeat (12) tick();

        // Fresh read afterwards completes normally
        resp_en = 1'b1; resp_d = 2; resp_data = 32'h13572468;
        tick();
        set_req(1, 1'b0, 1'b1, 20'h000a1, 32'h0);
        t = cyc;
        exp_lb(t + 2, 1'b0, 20'h000a1, 32'h0);
        exp_rd(t + 5, 4'b0010, 4'b0000, 32'h13572468);
        tick(); clear_reqs(); wait_idle();

        repeat (4) tick();
        fin = 1'b1;
    end

endmodule
`default_nettype wire

// File: doc/lb_rr_arbiter.md
Name: lb_rr_arbiter

Overview:
- Round-robin arbiter that shares one LBL local bus master port between NREQ requesters, such as the CPU lb_bridge, a host link and an FMC120 init sequencer.
- Each requester issues single-cycle write/read strobes and holds off further strobes while its busy flag is high.
- The arbiter serialises requests onto the downstream bus, tracks each outstanding read until lb_rvalid arrives or a timeout expires, and routes the read data back to the owning requester.
- It sits between the requesters and the local bus decoder, replacing fixed two-way merging.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ADW, 20, local bus address width.
- TIMEOUT, 255, maximum WAIT_RD cycles before a read is aborted (1..65535).
- ERR_DATA, 32'hdeadbeef, rdata returned on a read timeout.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_write  in  NREQ  per-requester single-cycle write strobe.
- req_read  in  NREQ  per-requester single-cycle read strobe.
- req_addr  in  NREQ*ADW  packed addresses; requester i uses bits [i*ADW +: ADW].
- req_wdata  in  NREQ*32  packed write data; requester i uses bits [i*32 +: 32].
- req_busy  out  NREQ  request of requester i is pending or in flight.
- req_rdata  out  32  read data, shared by all requesters; valid only with req_rvalid.
- req_rvalid  out  NREQ  one-cycle read-completion pulse, one-hot.
- req_rerr  out  NREQ  one-cycle pulse coincident with req_rvalid when the read timed out.
- lb_write  out  1  downstream write strobe.
- lb_read  out  1  downstream read strobe.
- lb_addr  out  ADW  downstream address.
- lb_wdata  out  32  downstream write data.
- lb_rdata  in  32  downstream read data.
- lb_rvalid  in  1  downstream read-data valid.
- drop_err  out  1  sticky flag: a strobe arrived while that requester was busy; cleared only by rst.

Behaviour:
- Reset: all outputs are 0, all pending slots are cleared, the state machine is IDLE, the round-robin pointer is 0 (requester 0 has highest priority), and the timeout counter is 0.
- Capture:
  - A strobe from requester i with req_busy[i]=0 latches addr, wdata and op into slot i at that edge.
  - req_busy[i] goes high the next cycle.
  - If write and read are asserted together, the request is a write and the read is discarded.
  - A strobe while req_busy[i]=1 is ignored and sets drop_err.
- State IDLE:
  - If any slot is pending, grant the first pending slot scanning from ptr upward, modulo NREQ.
  - Register lb_addr/lb_wdata from the granted slot, assert lb_write or lb_read for exactly one cycle, and go to ISSUE.
- State ISSUE (strobe cycle):
  - Write: clear the slot at the end of this cycle, set ptr = g+1 mod NREQ, go to IDLE.
  - Read: go to WAIT_RD; if lb_rvalid is high in this cycle, complete immediately.
- State WAIT_RD:
  - The counter increments each cycle without lb_rvalid.
  - On lb_rvalid: register req_rdata = lb_rdata and pulse req_rvalid[g] the next cycle.
  - If the counter reaches TIMEOUT-1 without lb_rvalid: req_rdata = ERR_DATA, and req_rvalid[g] and req_rerr[g] pulse together the next cycle.
  - If lb_rvalid arrives in the timeout cycle, it wins and there is no error.
  - In either case the slot is cleared, ptr = g+1, the counter resets, and the FSM goes to IDLE.
- Latency:
  - Strobe at cycle t gives req_busy high at t+1 and lb strobe at t+2.
  - Write: req_busy is low at t+3.
  - Read answered D cycles after the lb strobe (D>=0): req_rvalid and busy-low at t+3+D, with no read timeout.
- Throughput: one downstream strobe at most every 2 cycles; no transaction overlap; reads are never pipelined.
- lb_addr and lb_wdata hold their last values between transactions.
- lb_rvalid in IDLE, or after a timeout, is ignored.
- A requester may strobe again in the same cycle its req_busy returns low.
- rst mid-transaction aborts immediately: no req_rvalid is emitted and in-flight data is discarded.

Test Plan:
- Single write: req0 write addr 0x00123, data 0x5a5a0001 at t -> lb_write=1 only at t+2 with those values; req_busy[0] high t+1..t+2.
- Read, D=3: req2 read addr 0x00040; lb_rvalid with 0xcafef00d 3 cycles after lb_read -> req_rvalid=4'b0100 one cycle, req_rdata=0xcafef00d, req_rerr=0.
- Round-robin: all four requesters strobe writes in the same cycle, addr = id -> lb addresses 0,1,2,3 in order; then re-strobe req0 and req3 while ptr=0 -> req0 is served first.
- Timeout: TIMEOUT=8, read with no lb_rvalid -> after 8 WAIT_RD cycles req_rvalid[g]=req_rerr[g]=1 and req_rdata=0xdeadbeef; a late lb_rvalid afterwards is ignored.
- Busy violation and dual strobe:
  - Second strobe on req1 while busy -> drop_err=1 and only one lb transaction occurs.
  - Simultaneous write+read strobe -> one lb_write and no lb_read.
- Reset mid-read: rst asserted in WAIT_RD -> all outputs 0 next cycle, no req_rvalid, and a fresh request completes normally afterwards.
